// File: rtl/mdu_pkg.sv
// Shared op codes, FSM states and decode helpers for the HI/LO multiply/divide unit.
package mdu_pkg;

    localparam int DEFAULT_DATA_W = 32;

    typedef enum logic [4:0] {
        OP_NOP   = 5'h00,
        OP_MFHI  = 5'h10,
        OP_MFLO  = 5'h11,
        OP_MTHI  = 5'h12,
        OP_MTLO  = 5'h13,
        OP_MULT  = 5'h14,
        OP_MULTU = 5'h15,
        OP_MADD  = 5'h16,
        OP_MADDU = 5'h17,
        OP_MSUB  = 5'h18,
        OP_MSUBU = 5'h19,
        OP_DIV   = 5'h1A,
        OP_DIVU  = 5'h1B
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DFIX
    } mdu_state_e;

    function automatic logic is_mdu_op(input logic [4:0] op);
        return (op >= OP_MFHI) && (op <= OP_DIVU);
    endfunction

    // Ops that start a busy period (everything except the MF/MT moves).
    function automatic logic is_issue_op(input logic [4:0] op);
        return (op >= OP_MULT) && (op <= OP_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [4:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_divider.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per cycle.
module mdu_divider #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    localparam int CW = $clog2(W + 1);

    logic [CW-1:0] cnt;
    logic [W-1:0]  rem;
    logic [W-1:0]  quo;
    logic [W-1:0]  dvs;
    logic [W:0]    shifted;

    // Handshake: start is sampled on an edge while not busy and loads the operands;
    // busy is high for the W iterating cycles; done is high during the last of them,
    // and quotient/remainder hold their final values from that edge until the next start.
    assign busy      = (cnt != '0);
    assign done      = (cnt == CW'(1));
    assign quotient  = quo;
    assign remainder = rem;
    assign shifted   = {rem, quo[W-1]};

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
            rem <= '0;
            quo <= '0;
            dvs <= '0;
        end else if (start && !busy) begin
            cnt <= CW'(W);
            rem <= '0;
            quo <= dividend;
            dvs <= divisor;
        end else if (busy) begin
            if (shifted >= {1'b0, dvs}) begin
                rem <= W'(shifted - {1'b0, dvs});
                quo <= {quo[W-2:0], 1'b1};
            end else begin
                rem <= shifted[W-1:0];
                quo <= {quo[W-2:0], 1'b0};
            end
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit owning HI/LO, with MADD/MSUB accumulation
// and a combinational interlock for MDU ops presented while busy.
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int MUL_CYCLES = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              EX_Stall,
    input  logic              EX_Flush,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [4:0]        Operation,
    output logic [DATA_W-1:0] Result,
    output logic              ALU_Stall,
    output logic [DATA_W-1:0] out_HI,
    output logic [DATA_W-1:0] out_LO
);

    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

    mdu_state_e          state, state_next;
    mdu_op_e             op_q;
    logic [DATA_W-1:0]   a_q, b_q;
    logic [CNT_W-1:0]    cnt;
    logic                accept, issue, issue_div, mul_last, signed_mul;
    logic [2*DATA_W-1:0] ext_a, ext_b, prod, mul_res;
    logic                div_busy, div_done, quo_neg, rem_neg;
    logic [DATA_W-1:0]   div_a, div_b, div_quo, div_rem, fix_quo, fix_rem;

    assign accept    = (state == IDLE) && !EX_Stall && !EX_Flush && is_mdu_op(Operation);
    assign issue     = accept && is_issue_op(Operation);
    assign issue_div = issue && is_div_op(Operation);
    assign mul_last  = (state == MUL) && (cnt == CNT_LAST);

    // The divider sees magnitudes; signs are re-applied from the latched operands in DFIX.
    assign div_a = ((Operation == OP_DIV) && A[DATA_W-1]) ? -A : A;
    assign div_b = ((Operation == OP_DIV) && B[DATA_W-1]) ? -B : B;

    mdu_divider #(.W(DATA_W)) u_divider (
        .clock     (clock),
        .reset     (reset),
        .start     (issue_div),
        .dividend  (div_a),
        .divisor   (div_b),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    assign quo_neg = (op_q == OP_DIV) && (a_q[DATA_W-1] ^ b_q[DATA_W-1]);
    assign rem_neg = (op_q == OP_DIV) && a_q[DATA_W-1];
    assign fix_quo = quo_neg ? -div_quo : div_quo;
    assign fix_rem = rem_neg ? -div_rem : div_rem;

    assign signed_mul = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
    assign ext_a = signed_mul ? {{DATA_W{a_q[DATA_W-1]}}, a_q} : {{DATA_W{1'b0}}, a_q};
    assign ext_b = signed_mul ? {{DATA_W{b_q[DATA_W-1]}}, b_q} : {{DATA_W{1'b0}}, b_q};
    assign prod  = ext_a * ext_b;

    // Accumulation uses HI/LO as they stand at completion, not at issue.
    always_comb begin
        mul_res = prod;
        case (op_q)
            OP_MADD, OP_MADDU: mul_res = {out_HI, out_LO} + prod;
            OP_MSUB, OP_MSUBU: mul_res = {out_HI, out_LO} - prod;
            default:           mul_res = prod;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= OP_NOP;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            state <= state_next;
            if (issue) begin
                op_q <= mdu_op_e'(Operation);
                a_q  <= A;
                b_q  <= B;
                cnt  <= '0;
            end else if (state == MUL) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (issue) state_next = is_div_op(Operation) ? DIV : MUL;
            MUL:  if (mul_last) state_next = IDLE;
            DIV: begin
                if (div_done)       state_next = DFIX;
                else if (!div_busy) state_next = IDLE;
            end
            DFIX:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ALU_Stall = (state != IDLE) && is_mdu_op(Operation) && !EX_Flush;
        Result    = '0;
        if (Operation == OP_MFHI)      Result = out_HI;
        else if (Operation == OP_MFLO) Result = out_LO;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_HI <= '0;
            out_LO <= '0;
        end else if (mul_last) begin
            {out_HI, out_LO} <= mul_res;
        end else if (state == DFIX) begin
            if (b_q == '0) begin
                out_LO <= '1;
                out_HI <= a_q;
            end else begin
                out_LO <= fix_quo;
                out_HI <= fix_rem;
            end
        end else if (accept && (Operation == OP_MTHI)) begin
            out_HI <= A;
        end else if (accept && (Operation == OP_MTLO)) begin
            out_LO <= A;
        end
    end

endmodule

// File: tb/tb_mdu_hilo.sv
// Bench for mdu_hilo: arithmetic reference model checked every cycle, plus
// directed scenarios with hand-computed literal results and a randomized run.
module tb_mdu_hilo;
    import mdu_pkg::*;

    localparam int W     = 32;
    localparam int MC    = 4;
    localparam int DIV_N = W + 1;

    logic         clock = 1'b0;
    logic         reset, EX_Stall, EX_Flush;
    logic [W-1:0] A, B;
    logic [4:0]   Operation;
    logic [W-1:0] Result, out_HI, out_LO;
    logic         ALU_Stall;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    logic [4:0]   m_op = '0;
    int           m_busy = 0;

    mdu_hilo #(.DATA_W(W), .MUL_CYCLES(MC)) dut (
        .clock     (clock),
        .reset     (reset),
        .EX_Stall  (EX_Stall),
        .EX_Flush  (EX_Flush),
        .A         (A),
        .B         (B),
        .Operation (Operation),
        .Result    (Result),
        .ALU_Stall (ALU_Stall),
        .out_HI    (out_HI),
        .out_LO    (out_LO)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic in_set(input logic [4:0] op);
        return op inside {OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO, OP_MULT, OP_MULTU, OP_MADD,
                          OP_MADDU, OP_MSUB, OP_MSUBU, OP_DIV, OP_DIVU};
    endfunction

    // Result of the finished operation, from plain 64-bit arithmetic.
    task automatic model_complete();
        logic [63:0] acc, ps, pu;
        longint      sa, sb, q, r;
        acc = {m_hi, m_lo};
        sa  = $signed(m_a);
        sb  = $signed(m_b);
        ps  = sa * sb;
        pu  = {32'b0, m_a} * {32'b0, m_b};
        case (m_op)
            OP_MULT:  {m_hi, m_lo} = ps;
            OP_MULTU: {m_hi, m_lo} = pu;
            OP_MADD:  {m_hi, m_lo} = acc + ps;
            OP_MADDU: {m_hi, m_lo} = acc + pu;
            OP_MSUB:  {m_hi, m_lo} = acc - ps;
            OP_MSUBU: {m_hi, m_lo} = acc - pu;
            default: begin
                if (m_b == '0) begin
                    m_lo = '1;
                    m_hi = m_a;
                end else if (m_op == OP_DIV) begin
                    q = sa / sb;
                    r = sa % sb;
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end else begin
                    m_lo = m_a / m_b;
                    m_hi = m_a % m_b;
                end
            end
        endcase
    endtask

    always @(posedge clock) begin
        if (reset) begin
            m_hi = '0;
            m_lo = '0;
            m_busy = 0;
        end else if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) model_complete();
        end else if (!EX_Stall && !EX_Flush && in_set(Operation)) begin
            if (Operation == OP_MTHI) m_hi = A;
            else if (Operation == OP_MTLO) m_lo = A;
            else if (!(Operation inside {OP_MFHI, OP_MFLO})) begin
                m_op = Operation;
                m_a = A;
                m_b = B;
                m_busy = (Operation inside {OP_DIV, OP_DIVU}) ? DIV_N : MC;
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("stall", ALU_Stall, (m_busy > 0) && in_set(Operation) && !EX_Flush);
            check("result", Result, (Operation == OP_MFHI) ? m_hi :
                                    (Operation == OP_MFLO) ? m_lo : '0);
            check("hi", out_HI, m_hi);
            check("lo", out_LO, m_lo);
            check("busy", dut.state != IDLE, m_busy > 0);
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic do_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        Operation = op;
        A = a;
        B = b;
        tick();
        Operation = OP_NOP;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (dut.state != IDLE && n < 200) begin
            tick();
            n++;
        end
        check("wait_idle", dut.state == IDLE, 1'b1);
    endtask

    task automatic count_stall(output int c);
        c = 0;
        while (ALU_Stall && c < 200) begin
            tick();
            c++;
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        int c;
        logic [4:0] ops [14];
        ops = '{OP_NOP, 5'h1F, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO, OP_MULT, OP_MULTU,
                OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU, OP_DIV, OP_DIVU};

        reset = 1'b1; EX_Stall = 1'b0; EX_Flush = 1'b0;
        A = '0; B = '0; Operation = OP_NOP;
        tick(); tick();
        reset = 1'b0;
        chk_en = 1'b1;

        Operation = OP_MFHI;
        check("rst_hi", out_HI, 32'h0);
        check("rst_lo", out_LO, 32'h0);
        check("rst_stall", ALU_Stall, 1'b0);
        check("rst_result", Result, 32'h0);

        do_op(OP_MULT, 32'hFFFF_FFFF, 32'h2);
        Operation = OP_MFHI;
        count_stall(c);
        check("mult_stall_cycles", c, 32'd4);
        check("mult_hi", Result, 32'hFFFF_FFFF);
        check("mult_lo", out_LO, 32'hFFFF_FFFE);

        do_op(OP_MULTU, 32'hFFFF_FFFF, 32'h2);
        wait_idle();
        check("multu_hi", out_HI, 32'h1);
        check("multu_lo", out_LO, 32'hFFFF_FFFE);

        do_op(OP_DIV, 32'hFFFF_FFF9, 32'h2);
        Operation = OP_MFLO;
        count_stall(c);
        check("div_stall_cycles", c, 32'd33);
        check("div_quo", Result, 32'hFFFF_FFFD);
        check("div_rem", out_HI, 32'hFFFF_FFFF);

        do_op(OP_DIVU, 32'h1234, 32'h0);
        wait_idle();
        check("div0_lo", out_LO, 32'hFFFF_FFFF);
        check("div0_hi", out_HI, 32'h1234);

        do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle();
        check("ovf_lo", out_LO, 32'h8000_0000);
        check("ovf_hi", out_HI, 32'h0);

        do_op(OP_MTHI, 32'h0, 32'h0);
        do_op(OP_MTLO, 32'hFFFF_FFFF, 32'h0);
        do_op(OP_MADD, 32'h1, 32'h1);
        wait_idle();
        check("madd_hi", out_HI, 32'h1);
        check("madd_lo", out_LO, 32'h0);
        do_op(OP_MSUB, 32'h1, 32'h1);
        wait_idle();
        check("msub_hi", out_HI, 32'h0);
        check("msub_lo", out_LO, 32'hFFFF_FFFF);

        EX_Flush = 1'b1;
        do_op(OP_MULT, 32'h5, 32'h7);
        EX_Flush = 1'b0;
        check("flush_idle", dut.state == IDLE, 1'b1);
        check("flush_lo", out_LO, 32'hFFFF_FFFF);

        EX_Stall = 1'b1;
        Operation = OP_MTHI;
        A = 32'hABCD;
        tick(); tick();
        check("stall_no_write", out_HI, 32'h0);
        EX_Stall = 1'b0;
        tick();
        check("stall_release_write", out_HI, 32'hABCD);
        Operation = OP_NOP;

        do_op(OP_DIV, 32'd100, 32'd3);
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        Operation = OP_MFHI;
        check("rst_div_stall", ALU_Stall, 1'b0);
        check("rst_div_hi", out_HI, 32'h0);
        check("rst_div_lo", out_LO, 32'h0);
        check("rst_div_idle", dut.state == IDLE, 1'b1);
        do_op(OP_MULT, 32'd3, 32'd5);
        check("rst_mult_accept", dut.state == MUL, 1'b1);
        wait_idle();
        check("rst_mult_lo", out_LO, 32'd15);

        repeat (600) begin
            Operation = ops[$urandom_range(0, 13)];
            A = pick();
            B = pick();
            EX_Stall = ($urandom_range(0, 7) == 0);
            EX_Flush = ($urandom_range(0, 7) == 0);
            reset    = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0; EX_Stall = 1'b0; EX_Flush = 1'b0; Operation = OP_NOP;
        wait_idle();
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Parametrised multi-cycle multiply/divide unit owning the HI/LO register pair. It is the successor to the single-width ALU's HI/LO path.
- Sits in the EX stage beside the ALU and shares the ALU's clock, reset, EX_Stall and EX_Flush.
- Adds features the ALU lacks: a configurable datapath width, configurable multiply latency, an iterative signed/unsigned divider, MADD/MSUB accumulation, and an interlock (ALU_Stall) for HI/LO hazards.

Parameters:
- DATA_W, 32, operand/HI/LO width; must be even and ≥ 8.
- MUL_CYCLES, 4, multiply busy cycles; must be ≥ 1.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- EX_Stall  in  1  EX stage held; the presented op is not accepted.
- EX_Flush  in  1  presented op is cancelled.
- A  in  DATA_W  operand rs.
- B  in  DATA_W  operand rt.
- Operation  in  5  op code (mdu_pkg encoding; codes outside the MDU set mean no-op).
- Result  out  DATA_W  MFHI/MFLO read data.
- ALU_Stall  out  1  hazard interlock to the pipeline.
- out_HI  out  DATA_W  HI register.
- out_LO  out  DATA_W  LO register.

Behaviour:
- Reset: all of the following take effect on the first edge with reset=1, and any in-flight operation is abandoned:
  - state ← IDLE
  - out_HI = out_LO = 0
  - ALU_Stall = 0
  - Result = 0
- States: IDLE, MUL, DIV, DFIX.
- Accept condition: state=IDLE && !EX_Stall && !EX_Flush && Operation ∈ MDU set.
- Issue ops (MULT, MULTU, MADD, MADDU, MSUB, MSUBU, DIV, DIVU):
  - On accept, latch A, B and the op, then go to MUL (mult family) or DIV.
  - A, B and Operation may change freely after the accept edge.
- MTHI / MTLO: on accept, write out_HI/out_LO ← A at that edge, with no busy period.
- MFHI / MFLO:
  - Result = out_HI / out_LO combinationally; Result = 0 for any other op.
  - EX_Stall does not gate Result.
- ALU_Stall = (state≠IDLE) && Operation ∈ MDU set && !EX_Flush. It is combinational and covers every MDU op, including a new issue while busy.
- MUL state:
  - Counter runs MUL_CYCLES cycles.
  - At the last edge, {out_HI,out_LO} ← P, where P is the 2·DATA_W product (signed for MULT/MADD/MSUB, unsigned for the U variants).
  - MADD writes {HI,LO}+P; MSUB writes {HI,LO}−P, both modulo 2^(2·DATA_W).
  - The accumulate reads HI/LO at completion, not at issue.
- DIV state:
  - Restoring division on operand magnitudes, one quotient bit per cycle, DATA_W cycles.
  - Then DFIX for one cycle, which applies signs: quotient negated if signs differ; remainder takes the dividend's sign.
  - Writes out_LO ← quotient and out_HI ← remainder at the DFIX edge. Total busy = DATA_W+1 cycles.
- Timing: for an op accepted at edge E0 with busy length N (MUL_CYCLES or DATA_W+1):
  - State≠IDLE for the N cycles after E0.
  - HI/LO are updated at edge EN.
  - A dependent MFHI/MFLO held in EX sees ALU_Stall=1 for those N cycles and reads the new value in the cycle after EN.
- Boundary cases:
  - Divide by zero (DIV or DIVU): full N cycles; LO ← all-ones, HI ← A unmodified.
  - Signed overflow (min_int ÷ −1): LO ← min_int, HI ← 0.
- EX_Flush: affects only the presented op (no accept, no MT write, ALU_Stall=0). An in-flight operation always completes.
- EX_Stall during busy: no effect on the in-flight operation.

Decomposition:
- mdu_pkg holds:
  - mdu_op_e (5-bit op codes)
  - mdu_state_e
  - is_mdu_op() and is_issue_op() helper functions
  - DEFAULT_DATA_W
- Sub-module mdu_divider: iterative magnitude core with start/busy/done handshake, producing unsigned quotient and remainder. Sign handling and DFIX live in mdu_hilo.

Test Plan (DATA_W=32, MUL_CYCLES=4):
- MULT A=0xFFFFFFFF, B=2 → after 4 busy cycles HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (−7), B=2, then MFLO presented the next cycle → ALU_Stall high for 33 cycles, then Result=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=0x1234, B=0 → LO=0xFFFFFFFF, HI=0x1234. DIV A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- MTHI 0 and MTLO 0xFFFFFFFF, then MADD A=1, B=1 → HI=1, LO=0. MSUB A=1, B=1 → HI=0, LO=0xFFFFFFFF.
- MULT presented with EX_Flush=1 → no busy period, HI/LO unchanged. MTHI presented with EX_Stall=1 → no write; write lands on the first edge after EX_Stall falls.
- Reset asserted at cycle 10 of a DIV → next cycle ALU_Stall=0, HI=LO=0, state IDLE, and an immediate MULT is accepted.
